// File: rtl/bcd_ex3_seq_ctrl.sv
// bcd_ex3_seq_ctrl
//   Converts a packed multi-digit BCD word to Excess-3 using a single shared
//   one-digit BCD->Excess-3 converter. The converter handles one digit per clock.
//   A valid/ready handshake is used on both the input and output sides.
//   Any digit above 9 sets a sticky error flag for the word and produces nibble 4'h0.
//
// Ports
//   clk_i        clock, rising edge
//   rst_i        asynchronous reset, active-high
//   in_valid_i   upstream word valid
//   in_ready_o   block can accept a word (IDLE)
//   bcd_i        packed BCD word, digit 0 in bits [3:0]
//   out_valid_o  ex3_o / err_o valid (DONE)
//   out_ready_i  downstream accepts result
//   ex3_o        packed Excess-3 result, same digit ordering as bcd_i
//   err_o        at least one input digit was greater than 9
//   busy_o       conversion in progress (CONV)
module bcd_ex3_seq_ctrl #(
  parameter int DIGITS = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [4*DIGITS-1:0]   bcd_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [4*DIGITS-1:0]   ex3_o,
  output logic                  err_o,
  output logic                  busy_o
);

  localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(DIGITS - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CONV = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]          state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [4*DIGITS-1:0] in_q, in_d;
  logic [4*DIGITS-1:0] ex3_q, ex3_d;
  logic                err_q, err_d;

  // Shared single-digit converter, fed by the digit selected by the counter.
  logic [3:0] digit_sel;
  logic       digit_ok;
  logic [3:0] digit_ex3;

  always_comb begin
    digit_sel = in_q[{cnt_q, 2'b00} +: 4];
    digit_ok  = (digit_sel <= 4'd9);
    // 4'h0 is never a legal Excess-3 code, so it marks a bad digit in the result.
    digit_ex3 = digit_ok ? (digit_sel + 4'd3) : 4'h0;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    in_d    = in_q;
    ex3_d   = ex3_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid_i) begin
          in_d    = bcd_i;
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = ST_CONV;
        end
      end
      ST_CONV: begin
        ex3_d[{cnt_q, 2'b00} +: 4] = digit_ex3;
        if (!digit_ok) begin
          err_d = 1'b1;
        end
        if (cnt_q == LAST_CNT) begin
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        if (out_ready_i) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      in_q    <= '0;
      ex3_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      in_q    <= in_d;
      ex3_q   <= ex3_d;
      err_q   <= err_d;
    end
  end

  // All outputs decode registered state only.
  assign in_ready_o  = (state_q == ST_IDLE);
  assign busy_o      = (state_q == ST_CONV);
  assign out_valid_o = (state_q == ST_DONE);
  assign ex3_o       = ex3_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_bcd_ex3_seq_ctrl.sv
module tb_bcd_ex3_seq_ctrl;

  logic        clk;
  logic        rst;

  // DIGITS=4 instance
  logic        in_valid;
  logic        in_ready;
  logic [15:0] bcd;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] ex3;
  logic        err;
  logic        busy;

  // DIGITS=1 instance
  logic        in_valid1;
  logic        in_ready1;
  logic [3:0]  bcd1;
  logic        out_valid1;
  logic        out_ready1;
  logic [3:0]  ex3_1;
  logic        err1;
  logic        busy1;

  int tests_run;
  int tests_failed;

  bcd_ex3_seq_ctrl #(.DIGITS(4)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .bcd_i       (bcd),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .ex3_o       (ex3),
    .err_o       (err),
    .busy_o      (busy)
  );

  bcd_ex3_seq_ctrl #(.DIGITS(1)) dut1 (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (in_valid1),
    .in_ready_o  (in_ready1),
    .bcd_i       (bcd1),
    .out_valid_o (out_valid1),
    .out_ready_i (out_ready1),
    .ex3_o       (ex3_1),
    .err_o       (err1),
    .busy_o      (busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation time limit reached");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one word for one accept edge, then waits (bounded) for out_valid.
  // lat = number of edges after the accept edge until out_valid is seen.
  task automatic send_word(input logic [15:0] w, output int lat);
    in_valid = 1'b1;
    bcd      = w;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic check_word(input string name, input logic [15:0] w,
                            input logic [15:0] exp_ex3, input logic exp_err);
    int lat;
    send_word(w, lat);
    tests_run++;
    if (lat !== 4) begin
      tests_failed++;
      $display("FAIL %s_latency got=%0d want=4", name, lat);
    end
    tests_run++;
    if (ex3 !== exp_ex3 || err !== exp_err) begin
      tests_failed++;
      $display("FAIL %s_result got ex3=%h err=%b want ex3=%h err=%b",
               name, ex3, err, exp_ex3, exp_err);
    end
    // Release the result with out_ready held high, then expect IDLE.
    tick();
    tests_run++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s_release got out_valid=%b in_ready=%b want 0/1", name, out_valid, in_ready);
    end
    $display("[TB] %s bcd=%h ex3=%h err=%b lat=%0d", name, w, ex3, err, lat);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    tests_run++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || ex3 !== 16'h0 || err !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset4 got rdy=%b ov=%b busy=%b ex3=%h err=%b want 1/0/0/0000/0",
               in_ready, out_valid, busy, ex3, err);
    end
    tests_run++;
    if (in_ready1 !== 1'b1 || out_valid1 !== 1'b0 || busy1 !== 1'b0 || ex3_1 !== 4'h0 || err1 !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset1 got rdy=%b ov=%b busy=%b ex3=%h err=%b want 1/0/0/0/0",
               in_ready1, out_valid1, busy1, ex3_1, err1);
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
    $display("[TB] reset checked");
  endtask

  task automatic test_basic();
    int lat;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    bcd       = 16'h1234;
    tick();
    in_valid = 1'b0;
    tests_run++;
    if (busy !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL conv_flags got busy=%b rdy=%b ov=%b want 1/0/0", busy, in_ready, out_valid);
    end
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    tests_run++;
    if (lat !== 4) begin
      tests_failed++;
      $display("FAIL basic_latency got=%0d want=4", lat);
    end
    tests_run++;
    if (ex3 !== 16'h4567 || err !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_result got ex3=%h err=%b busy=%b want 4567/0/0", ex3, err, busy);
    end
    tick();
    $display("[TB] basic bcd=1234 ex3=%h lat=%0d", ex3, lat);
  endtask

  task automatic test_patterns();
    check_word("pat9870", 16'h9870, 16'hCBA3, 1'b0);
    check_word("pat0000", 16'h0000, 16'h3333, 1'b0);
    check_word("bad12A4", 16'h12A4, 16'h4507, 1'b1);
    check_word("clr5555", 16'h5555, 16'h8888, 1'b0);
  endtask

  task automatic test_backpressure();
    int lat;
    out_ready = 1'b0;
    send_word(16'h1234, lat);
    for (int i = 0; i < 5; i++) begin
      // Pulse a different word while in DONE; it must be ignored.
      in_valid = (i == 2);
      bcd      = 16'h9999;
      tick();
      tests_run++;
      if (out_valid !== 1'b1 || ex3 !== 16'h4567 || err !== 1'b0 || in_ready !== 1'b0) begin
        tests_failed++;
        $display("FAIL backpressure_hold%0d got ov=%b ex3=%h err=%b rdy=%b want 1/4567/0/0",
                 i, out_valid, ex3, err, in_ready);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    tests_run++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || ex3 !== 16'h4567) begin
      tests_failed++;
      $display("FAIL backpressure_release got ov=%b rdy=%b busy=%b ex3=%h want 0/1/0/4567",
               out_valid, in_ready, busy, ex3);
    end
    $display("[TB] backpressure held 5 cycles ex3=%h", ex3);
  endtask

  task automatic test_reset_abort();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    bcd       = 16'h1234;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
    tests_run++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || ex3 !== 16'h0 || err !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_reset got rdy=%b ov=%b busy=%b ex3=%h err=%b want 1/0/0/0000/0",
               in_ready, out_valid, busy, ex3, err);
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
    tests_run++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL abort_no_present got ov=%b rdy=%b want 0/1", out_valid, in_ready);
    end
    check_word("after_rst", 16'h0009, 16'h333C, 1'b0);
  endtask

  task automatic test_back_to_back();
    int acc_cycles[$];
    int nvalid;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    bcd       = 16'h1234;
    nvalid    = 0;
    for (int c = 0; c < 20; c++) begin
      if (in_ready) acc_cycles.push_back(c);
      tick();
      if (out_valid) begin
        nvalid++;
        tests_run++;
        if (ex3 !== 16'h4567 || err !== 1'b0) begin
          tests_failed++;
          $display("FAIL b2b_result got ex3=%h err=%b want 4567/0", ex3, err);
        end
      end
    end
    in_valid = 1'b0;
    tests_run++;
    if (acc_cycles.size() < 3) begin
      tests_failed++;
      $display("FAIL b2b_accepts got=%0d want>=3", acc_cycles.size());
    end else begin
      for (int k = 1; k < acc_cycles.size(); k++) begin
        tests_run++;
        if (acc_cycles[k] - acc_cycles[k-1] !== 6) begin
          tests_failed++;
          $display("FAIL b2b_gap%0d got=%0d want=6", k, acc_cycles[k] - acc_cycles[k-1]);
        end
      end
    end
    tests_run++;
    if (nvalid < 3) begin
      tests_failed++;
      $display("FAIL b2b_outputs got=%0d want>=3", nvalid);
    end
    // Drain whatever word is in flight.
    for (int c = 0; c < 8 && !in_ready; c++) tick();
    $display("[TB] back_to_back accepts=%0d outputs=%0d", acc_cycles.size(), nvalid);
  endtask

  task automatic test_single_digit();
    logic [3:0] vin  [2];
    logic [3:0] vex  [2];
    logic       verr [2];
    vin[0] = 4'h7; vex[0] = 4'hA; verr[0] = 1'b0;
    vin[1] = 4'hB; vex[1] = 4'h0; verr[1] = 1'b1;
    out_ready1 = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_valid1 = 1'b1;
      bcd1      = vin[i];
      tick();
      in_valid1 = 1'b0;
      tests_run++;
      if (busy1 !== 1'b1 || out_valid1 !== 1'b0) begin
        tests_failed++;
        $display("FAIL d1_conv%0d got busy=%b ov=%b want 1/0", i, busy1, out_valid1);
      end
      tick();
      tests_run++;
      if (out_valid1 !== 1'b1 || ex3_1 !== vex[i] || err1 !== verr[i]) begin
        tests_failed++;
        $display("FAIL d1_result%0d got ov=%b ex3=%h err=%b want 1/%h/%b",
                 i, out_valid1, ex3_1, err1, vex[i], verr[i]);
      end
      tick();
      $display("[TB] digits1 bcd=%h ex3=%h err=%b", vin[i], ex3_1, err1);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst        = 1'b1;
    in_valid   = 1'b0;
    bcd        = 16'h0;
    out_ready  = 1'b1;
    in_valid1  = 1'b0;
    bcd1       = 4'h0;
    out_ready1 = 1'b1;

    test_reset();
    test_basic();
    test_patterns();
    test_backpressure();
    test_reset_abort();
    test_back_to_back();
    test_single_digit();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
